// File: rtl/ram_dp_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_param
// Purpose  : Parametrised true dual-port synchronous RAM on a single clock.
//            This RAM is the shared scratch memory between two requesters.
//            After reset, a clear sweep writes INIT_VAL to every word.
//            Each port can be configured for read-first or write-first
//            behaviour.
//            An optional output register stage can be enabled.
//            Same-address write-write collisions resolve deterministically
//            and raise a flag.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            en_a/we_a/addr_a/din_a/dout_a - port A enable, write, address,
//                                            write data, read data
//            en_b/we_b/addr_b/din_b/dout_b - port B, same as port A
//            init_done           - high once the clear sweep has finished
//            collision           - one-cycle pulse after a same-address
//                                  write-write
// Revision : 1.0 - initial parametrised release
// ============================================================================
module ram_dp_param #(
    parameter int              DATA_W    = 5,
    parameter int              ADDR_W    = 4,
    parameter int              RD_MODE_A = 0,
    parameter int              RD_MODE_B = 0,
    parameter int              OUT_REG   = 0,
    parameter int              WR_PRIO   = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              init_done,
    output logic              collision
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_init_done;
    logic              r_coll;
    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rd_a;
    logic [DATA_W-1:0] r_rd_b;

    logic w_ready;
    logic w_rd_en_a;
    logic w_rd_en_b;
    logic w_wr_a;
    logic w_wr_b;
    logic w_coll;
    logic w_store_a;
    logic w_store_b;

    // Port inputs are ignored until the sweep has finished.
    assign w_ready   = (r_state == ST_READY);
    assign w_rd_en_a = w_ready & en_a;
    assign w_rd_en_b = w_ready & en_b;
    assign w_wr_a    = w_rd_en_a & we_a;
    assign w_wr_b    = w_rd_en_b & we_b;
    assign w_coll    = w_wr_a & w_wr_b & (addr_a == addr_b);
    // On a collision only the priority port stores.
    assign w_store_a = w_wr_a & ~(w_coll & (WR_PRIO != 0));
    assign w_store_b = w_wr_b & ~(w_coll & (WR_PRIO == 0));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:  if (&r_cnt) w_state_nxt = ST_READY;
            ST_READY: w_state_nxt = ST_READY;
            default:  w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_coll      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_init_done <= (w_state_nxt == ST_READY);
            r_coll      <= w_coll;
            if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
        end
    end

    // The array has no reset. While reset is held, word 0 is rewritten with INIT_VAL.
    // This is harmless because the sweep restarts from word 0.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else begin
            if (w_store_a) r_mem[addr_a] <= din_a;
            if (w_store_b) r_mem[addr_b] <= din_b;
        end
    end

    // The non-blocking array read returns the pre-edge word.
    // This gives read-first behaviour, and the cross-port reader sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            if (w_rd_en_a) r_rd_a <= (we_a && (RD_MODE_A != 0)) ? din_a : r_mem[addr_a];
            if (w_rd_en_b) r_rd_b <= (we_b && (RD_MODE_B != 0)) ? din_b : r_mem[addr_b];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_vld_a;
            logic              r_vld_b;
            logic [DATA_W-1:0] r_q_a;
            logic [DATA_W-1:0] r_q_b;
            // The second stage loads only behind a real access.
            // Output therefore holds when the port is idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_a <= 1'b0;
                    r_vld_b <= 1'b0;
                    r_q_a   <= '0;
                    r_q_b   <= '0;
                end else begin
                    r_vld_a <= w_rd_en_a;
                    r_vld_b <= w_rd_en_b;
                    if (r_vld_a) r_q_a <= r_rd_a;
                    if (r_vld_b) r_q_b <= r_rd_b;
                end
            end
            assign dout_a = r_q_a;
            assign dout_b = r_q_b;
        end else begin : g_out_direct
            assign dout_a = r_rd_a;
            assign dout_b = r_rd_b;
        end
    endgenerate

    assign init_done = r_init_done;
    assign collision = r_coll;

endmodule
`default_nettype wire
